// File: rtl/mxv_result_collector.sv
// mxv_result_collector: captures matrix-by-vector result words into a RAM, counts them
// against the expected row total and serves the stored vector through a registered read port.
module mxv_result_collector #(
    parameter int element_width = 32,
    parameter int no_of_units   = 8,
    parameter int depth         = 64,
    parameter int addr_width    = 6
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [31:0]                          total_rows,
    input  logic [no_of_units*element_width-1:0] result_in,
    input  logic                                 result_valid,
    input  logic                                 read_enable,
    input  logic [addr_width-1:0]                read_address,
    output logic [no_of_units*element_width-1:0] read_data,
    output logic                                 read_valid,
    output logic [addr_width:0]                  words_written,
    output logic                                 collect_done,
    output logic                                 overflow
);
    localparam int W  = no_of_units * element_width;
    localparam int LG = $clog2(no_of_units);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t                state_q, state_d;
    logic [32:0]           exp_q, exp_d, exp_new;
    logic [addr_width:0]   ww_q, ww_d, ww_inc;
    logic                  ovf_q, ovf_d, done_q, rv_q, we;
    logic [W-1:0]          rd_q;
    logic [W-1:0]          mem [depth];

    // 33-bit ceiling division so total_rows near 2^32 cannot wrap to a small count
    always_comb begin
        exp_new = ({1'b0, total_rows} + 33'(no_of_units - 1)) >> LG;
        ww_inc  = ww_q + 1'b1;
        state_d = state_q;
        exp_d   = exp_q;
        ww_d    = ww_q;
        ovf_d   = ovf_q;
        we      = 1'b0;
        if (start) begin
            exp_d   = exp_new;
            ww_d    = '0;
            ovf_d   = exp_new > 33'(depth);
            state_d = (exp_new == 33'd0 || exp_new > 33'(depth)) ? DONE : COLLECT;
        end else if (result_valid && state_q == COLLECT) begin
            we      = 1'b1;
            ww_d    = ww_inc;
            state_d = (33'(ww_inc) == exp_q) ? DONE : COLLECT;
        end else if (result_valid && state_q == DONE) begin
            ovf_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            exp_q   <= '0;
            ww_q    <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            rv_q    <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            ww_q    <= ww_d;
            ovf_q   <= ovf_d;
            done_q  <= state_d == DONE;
            rv_q    <= read_enable;
            if (read_enable) rd_q <= mem[read_address];
        end
    end

    // RAM contents survive reset; a same-edge read sees the pre-write word
    always_ff @(posedge clk) begin
        if (we) mem[ww_q[addr_width-1:0]] <= result_in;
    end

    assign read_data     = rd_q;
    assign read_valid    = rv_q;
    assign words_written = ww_q;
    assign collect_done  = done_q;
    assign overflow      = ovf_q;
endmodule

// File: doc/mxv_result_collector.md
# mxv_result_collector

Receiving end of the matrix-by-vector result stream. Captures each wide `mXv1_result` word when the multiplier control pulses `outsider_read_now`, stores it in an internal result-vector RAM, and counts words against the expected row total. It raises a done flag when the vector is complete and exposes a registered read port, so the next solver stage reads the product vector from this block.

## Interface
- `element_width`, 32, width of one scalar element
- `no_of_units`, 8, elements per result word; must be a power of two
- `depth`, 64, result RAM depth in words
- `addr_width`, 6, log2(`depth`)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `start`  in  1  one-cycle pulse; arms collection for a new vector
- `total_rows`  in  32  scalar rows expected; sampled only on `start`
- `result_in`  in  `no_of_units*element_width`  result word; unit 0 in the MSB slice
- `result_valid`  in  1  qualifies `result_in`; driven by `outsider_read_now`
- `read_enable`  in  1  read request
- `read_address`  in  `addr_width`  word address to read
- `read_data`  out  `no_of_units*element_width`  registered RAM output
- `read_valid`  out  1  high one cycle after an accepted read
- `words_written`  out  `addr_width+1`  words stored since the last `start`
- `collect_done`  out  1  level; the vector is complete
- `overflow`  out  1  sticky error flag

## Operation
- Reset values: `read_data`=0, `read_valid`=0, `words_written`=0, `collect_done`=0, `overflow`=0, state IDLE. RAM contents are not cleared.
- Expected word count: `exp_words = (total_rows + no_of_units - 1) >> log2(no_of_units)`.
  - Computed in 33 bits so it cannot wrap.
  - Latched into a register on `start`.
- The state machine has three states: IDLE, COLLECT, DONE.
- `start` in any state:
  - Clears `words_written`, `overflow` and `collect_done`.
  - Latches `exp_words`.
  - If `exp_words`==0, next state is DONE.
  - If `exp_words` > `depth`, sets `overflow` and goes to DONE.
  - Otherwise goes to COLLECT.
- In IDLE, `result_valid` is ignored: no write and no flag change.
- In COLLECT, `result_valid` does the following:
  - Writes `result_in` to RAM[`words_written`].
  - Increments `words_written`.
  - On the write that makes `words_written`==`exp_words`, moves to DONE.
- In DONE, `result_valid` sets `overflow` (sticky) and the word is dropped. `words_written` is unchanged.
- `collect_done` = (state==DONE), registered.
- `start` and `result_valid` in the same cycle: `start` wins and that word is discarded.
- The read port is independent of state, so it can be used in any state, including during collection.

## Timing
- Write: `result_valid` sampled at edge N. RAM is updated and `words_written` is incremented at edge N, visible in cycle N+1.
- Done: the final write at edge N drives `collect_done` high in cycle N+1.
- Back-to-back `result_valid` every cycle is accepted with no stalls.
- Start: `start` at edge N puts the new state and cleared counters in effect in cycle N+1. A `result_valid` in cycle N+1 is written to address 0.
- Read latency is 1 cycle:
  - `read_enable` with address A at edge N gives `read_data`=RAM[A] and `read_valid`=1 in cycle N+1.
  - `read_valid` is low in any cycle that does not follow a request.
  - `read_data` holds its last value when no read is requested.
- Same-edge read and write to one address: the read returns the old contents (read-before-write).
- Asynchronous `reset` mid-collection forces the reset values immediately, regardless of `clk`. The block stays in IDLE until the next `start`.

## Test plan
- Basic collection:
  - Stimulus: reset; `start` with `total_rows`=20, `no_of_units`=8; three `result_valid` pulses with words W0, W1, W2.
  - Required: `exp_words`=3; `collect_done` high the cycle after W2; reads of addresses 0..2 return W0..W2 with 1-cycle latency.
- Exact multiple and zero total:
  - `total_rows`=16: done after exactly 2 words.
  - `total_rows`=0: `collect_done` high the cycle after `start` and `words_written`=0.
- Overflow:
  - After done on 3 words, a 4th `result_valid` sets `overflow`=1; `words_written` stays 3 and RAM[3] is unmodified.
  - `total_rows`=600 (`exp_words` 75 > 64): `overflow` set and state DONE the cycle after `start`.
- Start collision:
  - `start` and `result_valid` in the same cycle: word dropped, `words_written`=0.
  - Next-cycle valid word lands at address 0.
- Read-during-write: read address 1 on the same edge that writes address 1. `read_data` shows the prior contents; a re-read returns the new word.
- Async reset mid-stream: assert `reset` between clock edges after 2 of 3 words. All outputs go to 0 without waiting for `clk`. Further `result_valid` is ignored until `start`.
